// File: rtl/multiplicador_pkg.sv
// Shared control-word encoding for the shift-add multiplier.
// The controller and the three universal register instances import the same constants.
package multiplicador_pkg;

    typedef logic [3:0] ctrl_word_t;

    localparam ctrl_word_t CTRL_HOLD  = 4'b0000;
    localparam ctrl_word_t CTRL_ADD   = 4'b1000;
    localparam ctrl_word_t CTRL_SHIFT = 4'b0100;
    localparam ctrl_word_t CTRL_DECR  = 4'b0010;
    localparam ctrl_word_t CTRL_LOAD  = 4'b0001;

endpackage

// File: rtl/multiplicador_control.sv
// Moore controller for the shift-add multiplier: sequences Load / Add / Shift-Decrement,
// owns the carry flip-flop E and cross-checks P's zero flag against its own iteration count.
module multiplicador_control
    import multiplicador_pkg::*;
#(
    parameter int ANCHO = 8,
    parameter int CNT_W = $clog2(ANCHO + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       q0,
    input  logic       p_zero,
    input  logic       sum_carry,
    output logic [3:0] ctrl_a,
    output logic [3:0] ctrl_q,
    output logic [3:0] ctrl_p,
    output logic       e_bit,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_EVAL  = 3'd2;
    localparam logic [2:0] S_ADD   = 3'd3;
    localparam logic [2:0] S_SHIFT = 3'd4;
    localparam logic [2:0] S_CHECK = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic [CNT_W-1:0] ANCHO_CNT = CNT_W'(ANCHO);

    logic [2:0]       state_r;
    logic [2:0]       state_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_s;
    logic             e_r;
    logic             e_s;
    logic             err_r;
    logic             err_s;
    logic             count_full_s;

    ctrl_word_t ctrl_a_r;
    ctrl_word_t ctrl_q_r;
    ctrl_word_t ctrl_p_r;
    ctrl_word_t ctrl_a_s;
    ctrl_word_t ctrl_q_s;
    ctrl_word_t ctrl_p_s;
    logic       busy_r;
    logic       busy_s;
    logic       done_r;
    logic       done_s;

    assign count_full_s = (count_r == ANCHO_CNT);

    // Next state; CHECK also terminates when the count says P should already be zero.
    always_comb begin
        state_s = S_IDLE;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_LOAD;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_LOAD:  state_s = S_EVAL;
            S_EVAL: begin
                if (q0) begin
                    state_s = S_ADD;
                end else begin
                    state_s = S_SHIFT;
                end
            end
            S_ADD:   state_s = S_SHIFT;
            S_SHIFT: state_s = S_CHECK;
            S_CHECK: begin
                if (p_zero || count_full_s) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_EVAL;
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Carry flip-flop, iteration count and sticky mismatch flag.
    always_comb begin
        e_s     = e_r;
        count_s = count_r;
        err_s   = err_r;
        case (state_r)
            S_LOAD: begin
                e_s     = 1'b0;
                count_s = {CNT_W{1'b0}};
                err_s   = 1'b0;
            end
            S_ADD: begin
                e_s = sum_carry;
            end
            S_SHIFT: begin
                e_s     = 1'b0;
                count_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            S_CHECK: begin
                if (p_zero != count_full_s) begin
                    err_s = 1'b1;
                end else begin
                    err_s = err_r;
                end
            end
            default: begin
                e_s     = e_r;
                count_s = count_r;
                err_s   = err_r;
            end
        endcase
    end

    // Output decode of the upcoming state so the registered outputs track the state register.
    always_comb begin
        ctrl_a_s = CTRL_HOLD;
        ctrl_q_s = CTRL_HOLD;
        ctrl_p_s = CTRL_HOLD;
        busy_s   = 1'b0;
        done_s   = 1'b0;
        case (state_s)
            S_LOAD: begin
                ctrl_a_s = CTRL_LOAD;
                ctrl_q_s = CTRL_LOAD;
                ctrl_p_s = CTRL_LOAD;
                busy_s   = 1'b1;
            end
            S_EVAL: begin
                busy_s = 1'b1;
            end
            S_ADD: begin
                ctrl_a_s = CTRL_ADD;
                busy_s   = 1'b1;
            end
            S_SHIFT: begin
                ctrl_a_s = CTRL_SHIFT;
                ctrl_q_s = CTRL_SHIFT;
                ctrl_p_s = CTRL_DECR;
                busy_s   = 1'b1;
            end
            S_CHECK: begin
                busy_s = 1'b1;
            end
            S_DONE: begin
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    // State and datapath-control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r  <= S_IDLE;
            count_r  <= {CNT_W{1'b0}};
            e_r      <= 1'b0;
            err_r    <= 1'b0;
            ctrl_a_r <= CTRL_HOLD;
            ctrl_q_r <= CTRL_HOLD;
            ctrl_p_r <= CTRL_HOLD;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            count_r  <= count_s;
            e_r      <= e_s;
            err_r    <= err_s;
            ctrl_a_r <= ctrl_a_s;
            ctrl_q_r <= ctrl_q_s;
            ctrl_p_r <= ctrl_p_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
        end
    end

    assign ctrl_a = ctrl_a_r;
    assign ctrl_q = ctrl_q_r;
    assign ctrl_p = ctrl_p_r;
    assign e_bit  = e_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign err    = err_r;

endmodule

// File: tb/tb_multiplicador_control.sv
// Bench: controller driving behavioural A/Q/P registers; products and latencies come from
// plain arithmetic on the operands.
module tb_multiplicador_control;
    import multiplicador_pkg::*;

    localparam int ANCHO = 8;

    logic       clk;
    logic       rst;
    logic       start;
    logic       q0;
    logic       p_zero;
    logic       sum_carry;
    logic [3:0] ctrl_a;
    logic [3:0] ctrl_q;
    logic [3:0] ctrl_p;
    logic       e_bit;
    logic       busy;
    logic       done;
    logic       err;

    logic [7:0] reg_a;
    logic [7:0] reg_q;
    logic [7:0] reg_b;
    logic [7:0] q_in;
    logic [3:0] reg_p;
    logic [8:0] sum9;
    bit         force_pz0;

    int checks;
    int errors;

    int         r_done;
    logic [15:0] r_prod;
    int         r_loads;
    int         r_busy_bad;
    int         r_e_bad;
    int         r_seq_bad;
    int         r_carry1;
    logic       r_err1;
    logic       r_err2;
    logic       r_err_done;

    typedef struct {
        logic [7:0]  b;
        logic [7:0]  q;
        logic [15:0] prod;
        int          done_cyc;
    } vec_t;

    vec_t vecs[6];

    multiplicador_control #(.ANCHO(ANCHO)) dut (
        .clk(clk), .rst(rst), .start(start), .q0(q0), .p_zero(p_zero),
        .sum_carry(sum_carry), .ctrl_a(ctrl_a), .ctrl_q(ctrl_q), .ctrl_p(ctrl_p),
        .e_bit(e_bit), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign sum9      = {1'b0, reg_a} + {1'b0, reg_b};
    assign sum_carry = sum9[8];
    assign q0        = reg_q[0];
    assign p_zero    = force_pz0 ? 1'b0 : (reg_p == 4'd0);

    // Universal registers reacting to the control words.
    always_ff @(posedge clk) begin
        if (!rst) begin
            reg_a <= 8'd0;
            reg_q <= 8'd0;
            reg_p <= 4'd0;
        end else begin
            case (ctrl_a)
                CTRL_LOAD:  reg_a <= 8'd0;
                CTRL_ADD:   reg_a <= sum9[7:0];
                CTRL_SHIFT: reg_a <= {e_bit, reg_a[7:1]};
                default:    reg_a <= reg_a;
            endcase
            case (ctrl_q)
                CTRL_LOAD:  reg_q <= q_in;
                CTRL_SHIFT: reg_q <= {reg_a[0], reg_q[7:1]};
                default:    reg_q <= reg_q;
            endcase
            case (ctrl_p)
                CTRL_LOAD: reg_p <= 4'(ANCHO);
                CTRL_DECR: reg_p <= reg_p - 4'd1;
                default:   reg_p <= reg_p;
            endcase
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // One multiplication; cycle n is the state after the n-th rising edge following start.
    task automatic run_mult(input logic [7:0] b, input logic [7:0] q, input bit hold, input bit seq);
        int  exp_e;
        bit  exp_e_valid;
        int  m;
        logic [3:0] ea, eq, ep;
        @(negedge clk);
        reg_b = b;
        q_in  = q;
        start = 1'b1;
        r_done = -1; r_prod = 16'd0; r_loads = 0; r_busy_bad = 0; r_e_bad = 0;
        r_seq_bad = 0; r_carry1 = 0; r_err1 = 1'bx; r_err2 = 1'bx; r_err_done = 1'bx;
        exp_e = 0; exp_e_valid = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (n == 1) r_err1 = err;
            if (n == 2) r_err2 = err;
            if (ctrl_a == CTRL_LOAD) begin
                if (n == 1) r_loads++;
                else r_loads += 100;
            end
            if (!done && !busy) r_busy_bad++;
            if (done && busy) r_busy_bad++;
            if (exp_e_valid && (int'(e_bit) != exp_e)) r_e_bad++;
            if (ctrl_a == CTRL_ADD) begin
                exp_e = int'(sum_carry);
                exp_e_valid = 1'b1;
                if (sum_carry) r_carry1++;
            end else if (ctrl_a == CTRL_SHIFT || ctrl_a == CTRL_LOAD) begin
                exp_e = 0;
                exp_e_valid = 1'b1;
            end
            if (seq) begin
                m = (n - 2) % 3;
                ea = CTRL_HOLD; eq = CTRL_HOLD; ep = CTRL_HOLD;
                if (n == 1) begin
                    ea = CTRL_LOAD; eq = CTRL_LOAD; ep = CTRL_LOAD;
                end else if (m == 1) begin
                    ea = CTRL_SHIFT; eq = CTRL_SHIFT; ep = CTRL_DECR;
                end
                if (ctrl_a != ea || ctrl_q != eq || ctrl_p != ep) r_seq_bad++;
            end
            if (done) begin
                r_done     = n;
                r_prod     = {reg_a, reg_q};
                r_err_done = err;
                break;
            end
        end
    endtask

    initial begin
        int adds;
        int got_done;
        logic [7:0] rb, rq;
        checks = 0;
        errors = 0;
        force_pz0 = 1'b0;
        reg_b = 8'd0;
        q_in  = 8'd0;

        vecs[0] = '{8'd0,   8'd0,   16'd0,     26};
        vecs[1] = '{8'd13,  8'd11,  16'd143,   29};
        vecs[2] = '{8'd255, 8'd255, 16'd65025, 34};
        vecs[3] = '{8'd1,   8'd255, 16'd255,   34};
        vecs[4] = '{8'd200, 8'd1,   16'd200,   27};
        vecs[5] = '{8'd7,   8'd128, 16'd896,   27};

        // Reset with random start activity.
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            start = 1'($urandom);
        end
        @(negedge clk);
        chk("rst_ctrl_a", int'(ctrl_a), int'(CTRL_HOLD));
        chk("rst_ctrl_q", int'(ctrl_q), int'(CTRL_HOLD));
        chk("rst_ctrl_p", int'(ctrl_p), int'(CTRL_HOLD));
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_e_bit", int'(e_bit), 0);
        chk("rst_err", int'(err), 0);
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        // Directed operand table.
        for (int i = 0; i < 6; i++) begin
            run_mult(vecs[i].b, vecs[i].q, 1'b0, vecs[i].q == 8'd0);
            chk($sformatf("vec%0d_product", i), int'(r_prod), int'(vecs[i].prod));
            chk($sformatf("vec%0d_done_cycle", i), r_done, vecs[i].done_cyc);
            chk($sformatf("vec%0d_err", i), int'(r_err_done), 0);
            chk($sformatf("vec%0d_busy", i), r_busy_bad, 0);
            chk($sformatf("vec%0d_single_load", i), r_loads, 1);
            chk($sformatf("vec%0d_e_bit_track", i), r_e_bad, 0);
            if (vecs[i].q == 8'd0) chk("zero_ctrl_sequence", r_seq_bad, 0);
            if (vecs[i].b == 8'd255 && vecs[i].q == 8'd255) chk("carry_seen", int'(r_carry1 > 0), 1);
        end

        // Random operands against plain multiplication.
        for (int i = 0; i < 8; i++) begin
            rb = 8'($urandom);
            rq = 8'($urandom);
            run_mult(rb, rq, 1'b0, 1'b0);
            chk($sformatf("rand%0d_product", i), int'(r_prod), int'(rb) * int'(rq));
            chk($sformatf("rand%0d_done_cycle", i), r_done, 2 + 3 * ANCHO + $countones(rq));
            chk($sformatf("rand%0d_e_bit_track", i), r_e_bad, 0);
        end

        // start held high: one LOAD per IDLE visit, immediate relaunch.
        run_mult(8'd13, 8'd11, 1'b1, 1'b0);
        chk("hold_product", int'(r_prod), 143);
        chk("hold_single_load", r_loads, 1);
        @(negedge clk);
        chk("hold_idle_busy", int'(busy), 0);
        chk("hold_idle_done", int'(done), 0);
        chk("hold_idle_ctrl_a", int'(ctrl_a), int'(CTRL_HOLD));
        @(negedge clk);
        chk("hold_relaunch_load", int'(ctrl_a), int'(CTRL_LOAD));
        start = 1'b0;
        got_done = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done) begin
                got_done = 1;
                break;
            end
        end
        chk("hold_second_done", got_done, 1);

        // Reset asserted while in ADD.
        @(negedge clk);
        reg_b = 8'd255;
        q_in  = 8'd255;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        adds = 0;
        for (int k = 0; k < 40; k++) begin
            if (ctrl_a == CTRL_ADD) adds++;
            if (adds == 2) break;
            @(negedge clk);
        end
        chk("midadd_reached_add", adds, 2);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("midadd_ctrl_a", int'(ctrl_a), int'(CTRL_HOLD));
        chk("midadd_ctrl_q", int'(ctrl_q), int'(CTRL_HOLD));
        chk("midadd_ctrl_p", int'(ctrl_p), int'(CTRL_HOLD));
        chk("midadd_busy", int'(busy), 0);
        chk("midadd_e_bit", int'(e_bit), 0);
        @(negedge clk);
        chk("midadd_stays_idle", int'(busy), 0);

        // Watchdog: P never reports zero.
        force_pz0 = 1'b1;
        run_mult(8'd5, 8'd0, 1'b0, 1'b0);
        chk("wd_done_cycle", r_done, 26);
        chk("wd_err_at_done", int'(r_err_done), 1);
        force_pz0 = 1'b0;
        for (int k = 0; k < 3; k++) @(negedge clk);
        chk("wd_err_sticky", int'(err), 1);
        run_mult(8'd3, 8'd2, 1'b0, 1'b0);
        chk("wd_err_during_load", int'(r_err1), 1);
        chk("wd_err_cleared", int'(r_err2), 0);
        chk("wd_next_product", int'(r_prod), 6);
        chk("wd_next_err", int'(r_err_done), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
